multicycle_core: RTL

- Multi-cycle successor to the single-cycle MIPS-subset processor.
- One FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- A single shared instruction/data memory port uses a req/ack handshake, so memory latency can vary.
- Adds SUB/AND/OR/SLT, BEQ, J and HALT, plus a retire/debug interface for the bench.

---
 rtl/core_pkg.sv | 70 +++++++
 rtl/core_regfile.sv | 38 +++
 rtl/multicycle_core.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states, ALU operations and the instruction classifier.
`timescale 1ns/1ps
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  typedef enum logic [3:0] {
    IC_NOP, IC_RTYPE, IC_ADDI, IC_LW, IC_SW, IC_BEQ, IC_BNE, IC_J, IC_HALT
  } iclass_t;

  // Unsupported opcodes and unsupported R-type functs both collapse to NOP.
  function automatic iclass_t decode_class(input logic [31:0] ir);
    iclass_t c;
    c = IC_NOP;
    unique case (ir[31:26])
      OP_RTYPE: begin
        if (ir[5:0] == FN_ADD || ir[5:0] == FN_SUB || ir[5:0] == FN_AND ||
            ir[5:0] == FN_OR  || ir[5:0] == FN_SLT)
          c = IC_RTYPE;
      end
      OP_ADDI: c = IC_ADDI;
      OP_LW:   c = IC_LW;
      OP_SW:   c = IC_SW;
      OP_BEQ:  c = IC_BEQ;
      OP_BNE:  c = IC_BNE;
      OP_J:    c = IC_J;
      OP_HALT: c = IC_HALT;
      default: c = IC_NOP;
    endcase
    return c;
  endfunction

  function automatic alu_op_t decode_alu(input logic [31:0] ir);
    alu_op_t a;
    a = ALU_ADD;
    if (ir[31:26] == OP_RTYPE) begin
      unique case (ir[5:0])
        FN_SUB:  a = ALU_SUB;
        FN_AND:  a = ALU_AND;
        FN_OR:   a = ALU_OR;
        FN_SLT:  a = ALU_SLT;
        default: a = ALU_ADD;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/core_regfile.sv
// GPR file: two asynchronous read ports, one synchronous write port,
// asynchronous clear, register 0 hard-wired to zero.
`timescale 1ns/1ps
module core_regfile #(
  parameter int unsigned NREGS = 32
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  localparam int unsigned AW = (NREGS > 2) ? $clog2(NREGS) : 1;

  logic [31:0]   regs [NREGS];
  logic [AW-1:0] a1, a2, aw;

  assign a1 = ra1[AW-1:0];
  assign a2 = ra2[AW-1:0];
  assign aw = wa[AW-1:0];

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i[AW-1:0]] <= '0;
    end else if (we && aw != '0) begin
      regs[aw] <= wd;
    end
  end

  assign rd1 = (a1 == '0) ? '0 : regs[a1];
  assign rd2 = (a2 == '0) ? '0 : regs[a2];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// single shared req/ack memory port, with retire/debug outputs.
`timescale 1ns/1ps
module multicycle_core
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        CLK,
  input  logic        RST_X,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        RETIRE,
  output logic [31:0] PC_OUT,
  output logic        HALTED
);

  state_t      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] a_q, b_q, aluout_q, mdr_q;
  logic [31:0] rd1, rd2, rf_wd;
  logic [4:0]  rf_wa;
  logic        rf_we;

  iclass_t     cls;
  alu_op_t     aluop;
  logic [31:0] imm_sext, op_b, alu_res, pc_plus4, br_target, j_target;

  assign cls       = decode_class(ir_q);
  assign aluop     = decode_alu(ir_q);
  assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign op_b      = (cls == IC_RTYPE) ? b_q : imm_sext;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    alu_res = '0;
    unique case (aluop)
      ALU_ADD: alu_res = a_q + op_b;
      ALU_SUB: alu_res = a_q - op_b;
      ALU_AND: alu_res = a_q & op_b;
      ALU_OR:  alu_res = a_q | op_b;
      ALU_SLT: alu_res = {31'd0, $signed(a_q) < $signed(op_b)};
      default: alu_res = '0;
    endcase
  end

  assign rf_we = (state_q == ST_WB);
  assign rf_wa = (cls == IC_RTYPE) ? ir_q[15:11] : ir_q[20:16];
  assign rf_wd = (cls == IC_LW) ? mdr_q : aluout_q;

  core_regfile #(.NREGS(NREGS)) u_rf (
    .CLK  (CLK),
    .RST_X(RST_X),
    .we   (rf_we),
    .ra1  (ir_q[25:21]),
    .ra2  (ir_q[20:16]),
    .wa   (rf_wa),
    .wd   (rf_wd),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  assign PC_OUT    = pc_q;
  assign MEM_WDATA = b_q;

  // run_q keeps FETCH from requesting until RST_X has been sampled high once.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = {pc_q[31:2], 2'b00};
    RETIRE   = 1'b0;
    HALTED   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          MEM_REQ = 1'b1;
          if (MEM_ACK) begin
            ir_d    = MEM_RDATA;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        unique case (cls)
          IC_J: begin
            pc_d    = j_target;
            RETIRE  = 1'b1;
            state_d = ST_FETCH;
          end
          IC_HALT: state_d = ST_HALT;
          IC_NOP: begin
            pc_d    = pc_plus4;
            RETIRE  = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        unique case (cls)
          IC_BEQ, IC_BNE: begin
            pc_d    = ((a_q == b_q) == (cls == IC_BEQ)) ? br_target : pc_plus4;
            RETIRE  = 1'b1;
            state_d = ST_FETCH;
          end
          IC_LW, IC_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        MEM_REQ  = 1'b1;
        MEM_WE   = (cls == IC_SW);
        MEM_ADDR = {aluout_q[31:2], 2'b00};
        if (MEM_ACK) begin
          if (cls == IC_SW) begin
            pc_d    = pc_plus4;
            RETIRE  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = pc_plus4;
        RETIRE  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: HALTED = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= ST_FETCH;
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (state_q == ST_DECODE) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (state_q == ST_EXEC) aluout_q <= alu_res;
      if (state_q == ST_MEM && MEM_ACK) mdr_q <= MEM_RDATA;
    end
  end

endmodule
